// File: rtl/synth_regs_pkg.sv
// Register write port definitions shared by the synth top level and the SPI bridge.
// A frame is the register number in its upper bits and the value in its lower bits.
package synth_regs_pkg;
  localparam int REG_NUMBER_WIDTH = 12;
  localparam int REG_VALUE_WIDTH  = 24;
  localparam int FRAME_BITS       = REG_NUMBER_WIDTH + REG_VALUE_WIDTH;

  typedef struct packed {
    logic [REG_NUMBER_WIDTH-1:0] number;
    logic [REG_VALUE_WIDTH-1:0]  value;
  } RegisterWrite_t;

  function automatic RegisterWrite_t frame_to_write(input logic [FRAME_BITS-1:0] frame);
    RegisterWrite_t w;
    w.number = frame[FRAME_BITS-1:REG_VALUE_WIDTH];
    w.value  = frame[REG_VALUE_WIDTH-1:0];
    return w;
  endfunction
endpackage

// File: rtl/spi_register_bridge_if.sv
// SPI pins plus the synth register write port, bundled for the bridge.
// The bridge uses the slave modport; the host side (board pins or a bench) uses master.
interface spi_register_bridge_if #(
  parameter int ERROR_COUNT_WIDTH = 8
);
  import synth_regs_pkg::*;

  logic                         i_SPI_SCLK;
  logic                         i_SPI_CS_N;
  logic                         i_SPI_MOSI;
  logic                         o_SPI_MISO;
  logic [REG_NUMBER_WIDTH-1:0]  o_RegisterNumber;
  logic [REG_VALUE_WIDTH-1:0]   o_RegisterValue;
  logic                         o_RegisterWriteEnable;
  logic [ERROR_COUNT_WIDTH-1:0] o_FrameErrorCount;

  modport slave (
    input  i_SPI_SCLK, i_SPI_CS_N, i_SPI_MOSI,
    output o_SPI_MISO, o_RegisterNumber, o_RegisterValue,
           o_RegisterWriteEnable, o_FrameErrorCount
  );

  modport master (
    output i_SPI_SCLK, i_SPI_CS_N, i_SPI_MOSI,
    input  o_SPI_MISO, o_RegisterNumber, o_RegisterValue,
           o_RegisterWriteEnable, o_FrameErrorCount
  );
endinterface

// File: rtl/spi_register_bridge_sync_edge_detect.sv
// Multi-flop pin synchronizer with a history flop for rise/fall pulse detection.
// Pulses are single-cycle and derived from the last stage against the history flop.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);
  logic [SYNC_STAGES:0] chain;
  logic                 hist_q;

  assign chain[0] = i_Async;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic stage_q;
      always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) stage_q <= RESET_VALUE;
        else         stage_q <= chain[gi];
      end
      assign chain[gi+1] = stage_q;
    end
  endgenerate

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) hist_q <= RESET_VALUE;
    else         hist_q <= chain[SYNC_STAGES];
  end

  assign o_Level = chain[SYNC_STAGES];
  assign o_Rise  = o_Level & ~hist_q;
  assign o_Fall  = ~o_Level & hist_q;
endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave turning 36-bit host frames into one-cycle synth register writes,
// counting malformed frames and echoing the last committed frame on MISO.
module spi_register_bridge
  import synth_regs_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int ERROR_COUNT_WIDTH = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  spi_register_bridge_if.slave  bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int CNT_W       = $clog2(FRAME_BITS + 1);
  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_level;
  logic unused_sclk_level, unused_cs_level, unused_mosi_rise, unused_mosi_fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sclk_sync (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(bus.i_SPI_SCLK),
    .o_Level(unused_sclk_level), .o_Rise(sclk_rise), .o_Fall(sclk_fall)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_cs_sync (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(bus.i_SPI_CS_N),
    .o_Level(unused_cs_level), .o_Rise(cs_rise), .o_Fall(cs_fall)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_mosi_sync (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(bus.i_SPI_MOSI),
    .o_Level(mosi_level), .o_Rise(unused_mosi_rise), .o_Fall(unused_mosi_fall)
  );

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;
  logic [FRAME_BITS-1:0]        shift_q, shift_d;
  logic [FRAME_BITS-1:0]        echo_q, echo_d;
  logic                         miso_q, miso_d;
  logic                         we_q, we_d;
  RegisterWrite_t               commit_q, commit_d;
  logic [ERROR_COUNT_WIDTH-1:0] err_q, err_d;
  logic [WARM_W-1:0]            warm_q;
  logic                         armed;
  logic [FRAME_BITS-1:0]        echo_window;

  // The CS_N chain resets high, so a pin held low across reset would look like
  // a fall once real samples arrive; falls are ignored until the chain has refilled.
  assign armed = (warm_q == WARM_W'(WARM_CYCLES));
  assign echo_window = echo_q << cnt_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)     warm_q <= '0;
    else if (!armed) warm_q <= warm_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    shift_d  = shift_q;
    echo_d   = echo_q;
    miso_d   = miso_q;
    we_d     = 1'b0;
    commit_d = commit_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          miso_d  = echo_q[FRAME_BITS-1];
        end
      end
      ST_SHIFT: begin
        // CS_N rise wins over a coincident SCLK edge.
        if (cs_rise) begin
          if (cnt_q == CNT_W'(FRAME_BITS) && !ovf_q) begin
            state_d = ST_COMMIT;
          end else begin
            if (err_q != '1) err_d = err_q + 1'b1;
            miso_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_level};
          if (cnt_q == CNT_W'(FRAME_BITS)) ovf_d = 1'b1;
          else                             cnt_d = cnt_q + 1'b1;
        end else if (sclk_fall) begin
          miso_d = echo_window[FRAME_BITS-1];
        end
      end
      ST_COMMIT: begin
        we_d     = 1'b1;
        commit_d = frame_to_write(shift_q);
        echo_d   = shift_q;
        miso_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      shift_q  <= '0;
      echo_q   <= '0;
      miso_q   <= 1'b0;
      we_q     <= 1'b0;
      commit_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      shift_q  <= shift_d;
      echo_q   <= echo_d;
      miso_q   <= miso_d;
      we_q     <= we_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_SPI_MISO            = miso_q;
  assign bus.o_RegisterNumber      = commit_q.number;
  assign bus.o_RegisterValue       = commit_q.value;
  assign bus.o_RegisterWriteEnable = we_q;
  assign bus.o_FrameErrorCount     = err_q;
endmodule

// File: tb/tb_spi_register_bridge.sv
// Bench for spi_register_bridge: an SPI host model drives frames, a frame-level
// reference model predicts commits, and a monitor scores every write strobe.
module tb_spi_register_bridge;
  import synth_regs_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_register_bridge_if #(.ERROR_COUNT_WIDTH(8)) bus ();

  spi_register_bridge #(.SYNC_STAGES(2), .ERROR_COUNT_WIDTH(8)) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: a frame is good iff exactly 36 SCLK rises precede the CS_N rise.
  logic [35:0] exp_q[$];
  logic [35:0] echo_m = '0;
  logic [35:0] last_m = '0;
  int          err_m  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  initial begin : monitor
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (bus.o_RegisterWriteEnable === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("commit_number", 64'(bus.o_RegisterNumber), 64'(e[35:24]));
          check("commit_value",  64'(bus.o_RegisterValue),  64'(e[23:0]));
          $display("commit num=0x%03h val=0x%06h", bus.o_RegisterNumber, bus.o_RegisterValue);
        end
      end
    end
  end

  // Clocks nbits of data (MSB first) at SCLK = clk/8, checking MISO just before each rise.
  task automatic clock_bits(input logic [63:0] data, input int nbits, input int first_idx,
                            input bit check_miso, input bit simul_last);
    for (int i = 0; i < nbits; i++) begin
      bus.i_SPI_MOSI = data[nbits-1-i];
      repeat (4) @(negedge clk);
      if (check_miso && (first_idx + i) < 36)
        check("miso_bit", 64'(bus.o_SPI_MISO), 64'(echo_m[35-(first_idx+i)]));
      bus.i_SPI_SCLK = 1'b1;
      if (simul_last && i == nbits - 1) bus.i_SPI_CS_N = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_SPI_SCLK = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] data, input int nbits, input bit simul_last,
                            input string tag);
    int  eff;
    bit  good;
    int  lat;
    eff  = simul_last ? nbits - 1 : nbits;
    good = (eff == 36);
    @(negedge clk);
    bus.i_SPI_SCLK = 1'b0;
    bus.i_SPI_CS_N = 1'b0;
    repeat (4) @(negedge clk);
    clock_bits(data, nbits, 0, 1'b1, simul_last);
    if (good) exp_q.push_back(data[35:0]);
    if (!simul_last) begin
      repeat (4) @(negedge clk);
      bus.i_SPI_CS_N = 1'b1;
    end
    if (good) begin
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (bus.o_RegisterWriteEnable === 1'b1) begin
          lat = k;
          break;
        end
      end
      check("strobe_latency", 64'(lat), 64'd4);
      echo_m = data[35:0];
      last_m = data[35:0];
    end else begin
      repeat (8) @(negedge clk);
      err_m = (err_m < 255) ? err_m + 1 : 255;
    end
    repeat (4) @(negedge clk);
    check("error_count", 64'(bus.o_FrameErrorCount), 64'(err_m));
    check("hold_number", 64'(bus.o_RegisterNumber), 64'(last_m[35:24]));
    check("hold_value",  64'(bus.o_RegisterValue),  64'(last_m[23:0]));
    $display("frame %s bits=%0d simul=%0b good=%0b err=%0d", tag, nbits, simul_last, good,
             bus.o_FrameErrorCount);
  endtask

  initial begin : stimulus
    logic [63:0] d;
    int          len;
    bus.i_SPI_SCLK = 1'b0;
    bus.i_SPI_CS_N = 1'b1;
    bus.i_SPI_MOSI = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_number", 64'(bus.o_RegisterNumber), 64'd0);
    check("reset_value",  64'(bus.o_RegisterValue),  64'd0);
    check("reset_we",     64'(bus.o_RegisterWriteEnable), 64'd0);
    check("reset_err",    64'(bus.o_FrameErrorCount), 64'd0);
    check("reset_miso",   64'(bus.o_SPI_MISO), 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    send_frame(64'h045_123456, 36, 1'b0, "t1_basic");
    send_frame(64'h001_00000F, 36, 1'b0, "t2_a");
    send_frame(64'h002_ABCDEF, 36, 1'b0, "t2_b_echo");
    send_frame(64'h0AA_555555, 35, 1'b0, "t3_short35");
    send_frame(64'h1AA_555555, 37, 1'b0, "t3_long37");

    while (err_m < 255) begin
      d = 64'($urandom);
      send_frame(d, $urandom_range(0, 3), 1'b0, "t4_fill");
    end
    send_frame(64'h3, 2, 1'b0, "t4_saturated");
    send_frame(64'h321_FEDCBA, 36, 1'b0, "t4_good_after_sat");

    send_frame(64'h5A5_C3C3C3, 36, 1'b1, "t6_simul_rise");

    for (int r = 0; r < 8; r++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       len = 35;
        1:       len = 37;
        default: len = 36;
      endcase
      send_frame(d, len, 1'b0, "random");
    end

    // Reset in the middle of a frame with CS_N held low.
    d = 64'h6B2_9D4E71;
    @(negedge clk);
    bus.i_SPI_CS_N = 1'b0;
    repeat (4) @(negedge clk);
    clock_bits(d >> 16, 20, 0, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    echo_m = '0;
    last_m = '0;
    err_m  = 0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_number", 64'(bus.o_RegisterNumber), 64'd0);
    check("midreset_err",    64'(bus.o_FrameErrorCount), 64'd0);
    check("midreset_miso",   64'(bus.o_SPI_MISO), 64'd0);
    clock_bits(d & 64'hFFFF, 16, 20, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bus.i_SPI_CS_N = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_err",    64'(bus.o_FrameErrorCount), 64'd0);
    check("post_reset_number", 64'(bus.o_RegisterNumber), 64'd0);
    check("post_reset_value",  64'(bus.o_RegisterValue), 64'd0);
    $display("frame t5_reset_midframe bits=20+16 err=%0d", bus.o_FrameErrorCount);
    send_frame(64'h7FF_FFFFFF, 36, 1'b0, "t5_after_reset");
    send_frame({$urandom, $urandom}, 36, 1'b0, "final_random");

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
